// File: rtl/macarray_seq.sv
// macarray_seq: operand latch and skewed-feed sequencer for the 4x4 systolic MAC array.
// Optional abort input is compiled in when MACSEQ_ABORT_EN is defined.
module macarray_seq #(
  parameter int DRAIN = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                size4,
  input  logic [63:0]         a_mat,
  input  logic [63:0]         b_mat,
`ifdef MACSEQ_ABORT_EN
  input  logic                abort,
`endif
  output logic                busy,
  output logic                done,
  output logic                clr,
  output logic [1:0]          enable,
  output logic                update_ready,
  output logic signed [3:0]   a_row0,
  output logic signed [3:0]   a_row1,
  output logic signed [3:0]   a_row2,
  output logic signed [3:0]   a_row3,
  output logic signed [3:0]   b_col0,
  output logic signed [3:0]   b_col1,
  output logic signed [3:0]   b_col2,
  output logic signed [3:0]   b_col3
);

  localparam int DATA_W = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FEED   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

  logic [2:0]  state_p0, state_d;
  logic [3:0]  beat_p0, beat_d;
  logic [3:0]  drn_p0, drn_d;
  logic        n4_p0, n4_d;
  logic [63:0] a_lat_p0, b_lat_p0;
  logic [3:0]  feed_last;
  logic        abort_req;
  int          n_act;
  logic signed [DATA_W-1:0] a_nxt [4];
  logic signed [DATA_W-1:0] b_nxt [4];

`ifdef MACSEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // A[i][t-i]: row i is delayed by i beats; elements outside NxN stay zero.
  function automatic logic signed [DATA_W-1:0] a_elem(input logic [63:0] m, input int i,
                                                     input int t, input int n);
    int k;
    k = t - i;
    if (i < n && k >= 0 && k < n) return m[16*i + 4*k +: DATA_W];
    return '0;
  endfunction

  // B[t-j][j]: column j is delayed by j beats.
  function automatic logic signed [DATA_W-1:0] b_elem(input logic [63:0] m, input int j,
                                                     input int t, input int n);
    int k;
    k = t - j;
    if (j < n && k >= 0 && k < n) return m[16*k + 4*j +: DATA_W];
    return '0;
  endfunction

  // F-1 = 3N-3 is the final beat index
  assign feed_last = n4_p0 ? 4'd9 : 4'd6;

  always_comb begin
    state_d = state_p0;
    beat_d  = beat_p0;
    drn_d   = drn_p0;
    n4_d    = n4_p0;
    case (state_p0)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          n4_d    = size4;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        beat_d  = 4'd0;
      end
      S_FEED: begin
        if (beat_p0 == feed_last) begin
          state_d = S_DRAIN;
          drn_d   = DRAIN_LAST;
        end else begin
          beat_d = beat_p0 + 4'd1;
        end
      end
      S_DRAIN: begin
        if (drn_p0 == 4'd0) state_d = S_UPDATE;
        else                drn_d   = drn_p0 - 4'd1;
      end
      S_UPDATE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_req && (state_p0 == S_CLEAR || state_p0 == S_FEED || state_p0 == S_DRAIN))
      state_d = S_IDLE;
  end

  // Feed values for the upcoming cycle, so every output leaves a register.
  always_comb begin
    n_act = n4_d ? 4 : 3;
    for (int i = 0; i < 4; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
    end
    if (state_d == S_FEED) begin
      for (int i = 0; i < 4; i++) begin
        a_nxt[i] = a_elem(a_lat_p0, i, int'(beat_d), n_act);
        b_nxt[i] = b_elem(b_lat_p0, i, int'(beat_d), n_act);
      end
    end
  end

  // ---- stage p0: state, latched operands and registered outputs ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0     <= S_IDLE;
      beat_p0      <= 4'd0;
      drn_p0       <= 4'd0;
      n4_p0        <= 1'b0;
      a_lat_p0     <= '0;
      b_lat_p0     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      clr          <= 1'b0;
      enable       <= 2'b00;
      update_ready <= 1'b0;
      a_row0       <= '0;
      a_row1       <= '0;
      a_row2       <= '0;
      a_row3       <= '0;
      b_col0       <= '0;
      b_col1       <= '0;
      b_col2       <= '0;
      b_col3       <= '0;
    end else begin
      state_p0 <= state_d;
      beat_p0  <= beat_d;
      drn_p0   <= drn_d;
      n4_p0    <= n4_d;
      if (state_p0 == S_IDLE && start) begin
        a_lat_p0 <= a_mat;
        b_lat_p0 <= b_mat;
      end
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_DONE);
      clr          <= (state_d == S_CLEAR);
      enable       <= (state_d == S_IDLE) ? 2'b00 : (n4_d ? 2'b11 : 2'b01);
      update_ready <= (state_d == S_UPDATE);
      a_row0       <= a_nxt[0];
      a_row1       <= a_nxt[1];
      a_row2       <= a_nxt[2];
      a_row3       <= a_nxt[3];
      b_col0       <= b_nxt[0];
      b_col1       <= b_nxt[1];
      b_col2       <= b_nxt[2];
      b_col3       <= b_nxt[3];
    end
  end

endmodule

// File: tb/tb_macarray_seq.sv
// tb_macarray_seq: directed bench for macarray_seq with a timeline model and a systolic-array result model.
module tb_macarray_seq;
  localparam int DRAIN_P = 2;
  localparam int BUDGET  = 3 + 10 + DRAIN_P + 6;
`ifdef MACSEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST, start, size4, abort;
  logic [63:0] a_mat, b_mat;
  logic busy, done, clr, update_ready;
  logic [1:0] enable;
  logic signed [3:0] a_row0, a_row1, a_row2, a_row3;
  logic signed [3:0] b_col0, b_col1, b_col2, b_col3;
  logic signed [3:0] ar [4];
  logic signed [3:0] bc [4];

  always #5 CLK = ~CLK;

  macarray_seq #(.DRAIN(DRAIN_P)) dut (
    .CLK(CLK), .RST(RST), .start(start), .size4(size4),
    .a_mat(a_mat), .b_mat(b_mat),
`ifdef MACSEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .clr(clr), .enable(enable), .update_ready(update_ready),
    .a_row0(a_row0), .a_row1(a_row1), .a_row2(a_row2), .a_row3(a_row3),
    .b_col0(b_col0), .b_col1(b_col1), .b_col2(b_col2), .b_col3(b_col3)
  );

  assign ar[0] = a_row0; assign ar[1] = a_row1; assign ar[2] = a_row2; assign ar[3] = a_row3;
  assign bc[0] = b_col0; assign bc[1] = b_col1; assign bc[2] = b_col2; assign bc[3] = b_col3;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int nib(input logic [63:0] v, input int idx);
    logic signed [3:0] x;
    x = v[4*idx +: 4];
    return int'(x);
  endfunction

  function automatic logic [63:0] pack(input int m [4][4]);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) v[16*r + 4*c +: 4] = 4'(m[r][c]);
    return v;
  endfunction

  // Timeline model: m_c counts cycles since the accepting edge (CLEAR is cycle 1).
  bit m_act = 1'b0;
  int m_c   = 0;
  int m_n   = 4;
  int m_A [4][4];
  int m_B [4][4];

  always @(posedge CLK) begin
    if (RST) m_act <= 1'b0;
    else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1;
        m_c   <= 1;
        m_n   <= size4 ? 4 : 3;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            m_A[r][c] <= nib(a_mat, 4*r + c);
            m_B[r][c] <= nib(b_mat, 4*r + c);
          end
      end
    end else if (m_c == 3 + (3*m_n - 2) + DRAIN_P) m_act <= 1'b0;
    else if (ABORT_EN && abort && m_c <= 1 + (3*m_n - 2) + DRAIN_P) m_act <= 1'b0;
    else m_c <= m_c + 1;
  end

  int cap_a [4][10];
  int cap_b [4][10];
  int last_c [4][4];

  always @(negedge CLK) begin : cmp
    logic [63:0] ev, av;
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    int f, t, bad, s_dut, s_ref, ta, tb;
    if (chk_en) begin
      f = 3*m_n - 2;
      for (int i = 0; i < 4; i++) begin ea[i] = 4'd0; eb[i] = 4'd0; end
      if (m_act && m_c >= 2 && m_c <= 1 + f) begin
        t = m_c - 2;
        for (int i = 0; i < 4; i++) begin
          if (i < m_n && t >= i && t - i < m_n) ea[i] = 4'(m_A[i][t-i]);
          if (i < m_n && t >= i && t - i < m_n) eb[i] = 4'(m_B[t-i][i]);
          cap_a[i][t] = int'(ar[i]);
          cap_b[i][t] = int'(bc[i]);
        end
      end
      ev = {26'd0, m_act, (m_act && m_c == 3 + f + DRAIN_P), (m_act && m_c == 1),
            (m_act ? ((m_n == 4) ? 2'b11 : 2'b01) : 2'b00), (m_act && m_c == 2 + f + DRAIN_P),
            ea[3], ea[2], ea[1], ea[0], eb[3], eb[2], eb[1], eb[0]};
      av = {26'd0, busy, done, clr, enable, update_ready,
            a_row3, a_row2, a_row1, a_row0, b_col3, b_col2, b_col1, b_col0};
      check($sformatf("outputs@%0t", $time), av, ev);
      // At commit: accumulate the captured feeds the way the PE grid sees them.
      if (m_act && m_c == 3 + f + DRAIN_P) begin
        bad = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            s_dut = 0;
            for (int tau = 0; tau < f + 7; tau++) begin
              ta = tau - j; tb = tau - i;
              if (ta >= 0 && ta < f && tb >= 0 && tb < f) s_dut += cap_a[i][ta] * cap_b[j][tb];
            end
            s_ref = 0;
            if (i < m_n && j < m_n)
              for (int k = 0; k < m_n; k++) s_ref += m_A[i][k] * m_B[k][j];
            last_c[i][j] = s_dut;
            if (s_dut != s_ref) bad++;
          end
        check("result_C", 64'(bad), 64'd0);
      end
    end
  end

  task automatic run(input bit n4, input logic [63:0] am, input logic [63:0] bm,
                     input int pk, input int rk, input int ak, input bit pd,
                     output int lat, output int upd_k);
    lat = 0; upd_k = 0;
    @(posedge CLK); #1;
    start = 1'b1; size4 = n4; a_mat = am; b_mat = bm;
    @(posedge CLK); #1;
    start = 1'b0; size4 = ~n4;
    a_mat = {$urandom, $urandom}; b_mat = {$urandom, $urandom};
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge CLK);
      if (update_ready) upd_k = k;
      if (done) lat = k;
      start = (k == pk) || (pd && done);
      RST   = (k == rk);
      abort = (k == ak);
      if (done) break;
    end
    @(posedge CLK); #1;
    start = 1'b0; RST = 1'b0; abort = 1'b0;
  endtask

  int ma [4][4];
  int mb [4][4];
  int lat, upd, bad;

  initial begin
    RST = 1'b1; start = 1'b1; size4 = 1'b1; abort = 1'b0;
    a_mat = 64'h0123_4567_89ab_cdef; b_mat = 64'hfedc_ba98_7654_3210;
    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check("reset_outs", {26'd0, busy, done, clr, enable, update_ready,
          a_row3, a_row2, a_row1, a_row0, b_col3, b_col2, b_col1, b_col0}, 64'd0);
    RST = 1'b0;
    repeat (2) @(posedge CLK); #1;
    check("no_accept_in_rst", {63'd0, busy}, 64'd0);

    // 4x4 identity times B[k][j]=j+1
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin ma[i][j] = (i == j) ? 1 : 0; mb[i][j] = j + 1; end
    run(1'b1, pack(ma), pack(mb), 0, 0, 0, 1'b0, lat, upd);
    check("ident_done_lat", 64'(lat), 64'd15);
    check("ident_upd_lat", 64'(upd), 64'd14);
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (last_c[i][j] != j + 1) bad++;
    check("ident_C", 64'(bad), 64'd0);

    // Skew pattern, with start pulses in FEED and in DONE that must be ignored
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin ma[i][j] = 4*i + j - 8; mb[i][j] = 1; end
    run(1'b1, pack(ma), pack(mb), 5, 0, 0, 1'b1, lat, upd);
    check("skew_done_lat", 64'(lat), 64'd15);
    check("skew_a_row2_t3", 64'(cap_a[2][3]), 64'd1);
    bad = 0;
    for (int t = 0; t < 10; t++) if ((t < 3 || t > 6) && cap_b[3][t] != 0) bad++;
    check("skew_b_col3_zero", 64'(bad), 64'd0);
    @(negedge CLK);
    check("start_in_done_ignored", {63'd0, busy}, 64'd0);

    // 3x3 mode, every element 7 including the unused row/col
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ma[i][j] = 7; mb[i][j] = 7; end
    run(1'b0, pack(ma), pack(mb), 0, 0, 0, 1'b0, lat, upd);
    check("n3_done_lat", 64'(lat), 64'd12);
    bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) if (last_c[i][j] != ((i < 3 && j < 3) ? 147 : 0)) bad++;
    check("n3_C", 64'(bad), 64'd0);

    // Reset at FEED beat 5 (cycle s+7)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin ma[i][j] = i - j; mb[i][j] = j - 2; end
    run(1'b1, pack(ma), pack(mb), 0, 7, 0, 1'b0, lat, upd);
    check("rst_no_done", 64'(lat), 64'd0);
    check("rst_no_update", 64'(upd), 64'd0);
    check("rst_idle", {63'd0, busy}, 64'd0);

`ifdef MACSEQ_ABORT_EN
    // Abort at FEED beat 4 (cycle s+6), then a clean full run
    run(1'b1, pack(ma), pack(mb), 0, 0, 6, 1'b0, lat, upd);
    check("abort_no_done", 64'(lat), 64'd0);
    check("abort_no_update", 64'(upd), 64'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin ma[i][j] = (i == j) ? 1 : 0; mb[i][j] = j + 1; end
    run(1'b1, pack(ma), pack(mb), 0, 0, 0, 1'b0, lat, upd);
    check("post_abort_lat", 64'(lat), 64'd15);
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (last_c[i][j] != j + 1) bad++;
    check("post_abort_C", 64'(bad), 64'd0);
`endif

    // Random operands, both sizes
    for (int r = 0; r < 3; r++) begin
      run(r != 1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 1'b0, lat, upd);
      check("rand_done_lat", 64'(lat), (r != 1) ? 64'd15 : 64'd12);
    end

    repeat (3) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/macarray_seq.md
# macarray_seq

Sequencing controller for the 4x4 systolic MAC array. It latches a 4x4 A operand and a 4x4 B operand of signed 4-bit elements on a start handshake, and clears the array accumulators. It then streams skewed A rows and B columns into the array, drains the pipeline, pulses `update_ready` so the PEs commit their results, and reports completion. It sits between the CPU-side custom-IP register interface and the array instance.

## Interface
- `DRAIN`, default 2: zero-input cycles after the last operand beat, covering PE pipeline latency (1..15).
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `size4`  in  1  1 = 4x4 product (N=4); 0 = 3x3 product (N=3, row/col 3 idle). Sampled with `start`.
- `a_mat`  in  64  A[i][k] at bits [16i+4k+3 : 16i+4k], signed.
- `b_mat`  in  64  B[k][j] at bits [16k+4j+3 : 16k+4j], signed.
- `abort`  in  1  present only with MACSEQ_ABORT_EN.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when results are committed.
- `clr`  out  1  accumulator clear to the array.
- `enable`  out  2  array enable: 2'b11 for N=4, 2'b01 for N=3, 2'b00 in IDLE.
- `update_ready`  out  1  result-commit strobe to the array.
- `a_row0..a_row3`  out  4 each  signed A feed, row i.
- `b_col0..b_col3`  out  4 each  signed B feed, column j.

## Operation
- States: IDLE → CLEAR → FEED → DRAIN → UPDATE → DONE → IDLE.
- IDLE: all outputs 0. If `start`=1, latch `a_mat`, `b_mat`, and `size4`, then go to CLEAR.
- CLEAR, 1 cycle: `clr`=1, feeds 0, `enable` set per N.
- FEED, F=3N-2 cycles (10 for N=4, 7 for N=3), beat counter t=0..F-1:
  - a_row_i = A[i][t-i] if i<N and 0≤t-i<N, else 0.
  - b_col_j = B[t-j][j] if j<N and 0≤t-j<N, else 0.
- DRAIN, `DRAIN` cycles: feeds 0, `enable` held.
- UPDATE, 1 cycle: `update_ready`=1, feeds 0.
- DONE, 1 cycle: `done`=1, `enable` still held. Then go to IDLE, where `enable` returns to 00.
- `start` in any state other than IDLE is ignored; no queuing. `start` during the DONE cycle is also ignored.
- Operand inputs may change freely after acceptance; only the latched copy is used.
- Elements outside NxN are never driven nonzero, even if `a_mat`/`b_mat` hold nonzero data there.
- Counter width is 4 bits. The beat counter must not wrap: FEED exits exactly at t=F-1, and DRAIN uses a separate count from `DRAIN`-1 down to 0.
- `RST`=1 in any state, including mid-FEED: next cycle IDLE, all outputs 0, latched operands cleared. The array then holds partial sums until the next CLEAR.

## Timing
- All outputs are registered. Values listed per state are visible during the cycle the FSM is in that state.
- `start` sampled at edge s gives: CLEAR in cycle s+1, FEED in s+2..s+1+F, DRAIN in s+2+F..s+1+F+DRAIN, UPDATE in s+2+F+DRAIN, `done` in s+3+F+DRAIN.
- N=4, DRAIN=2: `done` 15 cycles after the start edge. N=3: 12 cycles.
- `busy` rises in cycle s+1 and falls in the cycle after `done`.
- Back-to-back: the earliest next accepted `start` is at the edge ending the first IDLE cycle after DONE.

## Configuration
- `MACSEQ_ABORT_EN` defined: the `abort` port exists. `abort`=1 in CLEAR, FEED, or DRAIN moves the FSM to IDLE next cycle and zeroes the feeds, without `update_ready` or `done`. `abort` in UPDATE or DONE is ignored.
- Not defined: no `abort` port, and the sequence always runs to completion.

## Test plan
- Reset: hold `RST` 2 cycles → all outputs 0, `busy`=0. `start` asserted during `RST` is not accepted.
- 4x4 identity: A=I, B[k][j]=j+1, DRAIN=2 → `done` at s+15; `update_ready` at s+14; committed C[i][j]=j+1.
- Skew check: A[i][k]=4i+k-8, B=all 1s → a_row2 in FEED beat t=3 is A[2][1]=1; b_col3=0 in beats 0..2 and 7..9.
- 3x3 mode: `size4`=0, all elements 7 → F=7, `enable`=01, a_row3=b_col3=0 throughout, C[i][j]=147 for i,j<3, `done` at s+12.
- Boundary: `start` pulsed in FEED and in the DONE cycle is ignored. `RST` at FEED beat 5 gives IDLE the next cycle, with no `done` and no `update_ready`.
- With MACSEQ_ABORT_EN: `abort` at FEED beat 4 → IDLE next cycle, no `done`. A following `start` runs a full sequence and produces correct results after CLEAR.
